// File: rtl/trail_pkg.sv
// Shared types and elaboration-time helpers for the motion-trail overlay.
package trail_pkg;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        v;
    } trail_entry_t;

    // Sprite side for history entry i, clamped at min so it never goes negative.
    function automatic logic [11:0] trail_size(input int i, input int head, input int step,
                                               input int min);
        int s;
        s = head - i * step;
        if (s < min) s = min;
        return 12'(s);
    endfunction

    function automatic logic [23:0] trail_fade(input logic [23:0] color, input logic [3:0] age);
        logic [2:0] sh;
        sh = (age > 4'd7) ? 3'd7 : age[2:0];
        return {color[23:16] >> sh, color[15:8] >> sh, color[7:0] >> sh};
    endfunction

endpackage

// File: rtl/trail_render_if.sv
// Pixel/tracker inputs and trail outputs of trail_render, grouped as one bundle.
interface trail_render_if;
    logic        nf_in;
    logic        clear_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic        valid_in;
    logic [23:0] color_in;
    logic [23:0] color_out;
    logic        hit_out;

    modport master (
        output nf_in, clear_in, hcount_in, vcount_in, x_in, y_in, valid_in, color_in,
        input  color_out, hit_out
    );

    modport slave (
        input  nf_in, clear_in, hcount_in, vcount_in, x_in, y_in, valid_in, color_in,
        output color_out, hit_out
    );
endinterface

// File: rtl/trail_stage_hit.sv
// Combinational coverage test of one history entry's square sprite against the current pixel.
module trail_stage_hit
    import trail_pkg::*;
#(
    parameter logic [11:0] SIZE = 12'd16
) (
    input  logic [10:0]  hcount,
    input  logic [9:0]   vcount,
    input  trail_entry_t entry,
    output logic         hit
);
    logic [11:0] x_end;
    logic [10:0] y_end;

    // Widened sums: a sprite near the right/bottom edge clips instead of wrapping to 0.
    assign x_end = {1'b0, entry.x} + SIZE;
    assign y_end = {1'b0, entry.y} + SIZE[10:0];

    assign hit = entry.v
               && (hcount >= entry.x) && ({1'b0, hcount} < x_end)
               && (vcount >= entry.y) && ({1'b0, vcount} < y_end);
endmodule

// File: rtl/trail_render.sv
// Motion-trail overlay: decimated position history drawn as shrinking sprites, newest on top.
// Optional TRAIL_FADE_EN halves each colour channel per age step.
module trail_render
    import trail_pkg::*;
#(
    parameter int DEPTH     = 6,
    parameter int DECIM     = 1,
    parameter int HEAD_SIZE = 16,
    parameter int SIZE_STEP = 3,
    parameter int MIN_SIZE  = 2
) (
    input  logic         clk_in,
    input  logic         rst_in,
    trail_render_if.slave bus
);
`ifdef TRAIL_FADE_EN
    localparam bit FADE = 1'b1;
`else
    localparam bit FADE = 1'b0;
`endif

    logic [7:0]       cnt;
    logic             accept;
    trail_entry_t     hist [DEPTH];
    logic [DEPTH-1:0] hits;
    logic             any_hit;
    logic [3:0]       sel;
    logic [23:0]      sel_color;

    assign accept = bus.nf_in && (cnt == 8'd0);

    // Clear wins over a same-cycle accept: no shift, counter restarts.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt <= 8'd0;
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
        end else if (bus.clear_in) begin
            cnt <= 8'd0;
            for (int i = 0; i < DEPTH; i++) hist[i].v <= 1'b0;
        end else begin
            if (bus.nf_in) cnt <= (cnt == 8'(DECIM - 1)) ? 8'd0 : cnt + 8'd1;
            if (accept) begin
                hist[0] <= {bus.x_in, bus.y_in, bus.valid_in};
                for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        trail_stage_hit #(
            .SIZE(trail_size(g, HEAD_SIZE, SIZE_STEP, MIN_SIZE))
        ) u_stage (
            .hcount(bus.hcount_in),
            .vcount(bus.vcount_in),
            .entry (hist[g]),
            .hit   (hits[g])
        );
    end

    always_comb begin
        any_hit = 1'b0;
        sel     = 4'd0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hits[i]) begin
                any_hit = 1'b1;
                sel     = 4'(i);
            end
        end
    end

    assign sel_color = FADE ? trail_fade(bus.color_in, sel) : bus.color_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bus.color_out <= 24'h0;
            bus.hit_out   <= 1'b0;
        end else begin
            bus.color_out <= any_hit ? sel_color : 24'h0;
            bus.hit_out   <= any_hit;
        end
    end
endmodule

// File: tb/tb_trail_render.sv
// Self-checking bench for trail_render: DECIM=1 and DECIM=3 instances, scoreboarded pixel probes.
module tb_trail_render;

    localparam logic [23:0] COL = 24'hF0_80_40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trail_render_if bus1();
    trail_render_if bus3();

    trail_render #(.DEPTH(6), .DECIM(1)) dut (.clk_in(clk), .rst_in(rst), .bus(bus1.slave));
    trail_render #(.DEPTH(6), .DECIM(3)) dut3 (.clk_in(clk), .rst_in(rst), .bus(bus3.slave));

    typedef struct {
        int          sel;
        logic        hit;
        logic [23:0] col;
        string       name;
    } exp_t;

    typedef struct {
        int   h;
        int   v;
        logic hit;
        int   age;
    } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [23:0] exp_col(input int age);
        logic [23:0] c;
        int s;
        c = COL;
        s = (age > 7) ? 7 : age;
`ifdef TRAIL_FADE_EN
        return {c[23:16] >> s, c[15:8] >> s, c[7:0] >> s};
`else
        if (s < 0) return 24'h0;
        return c;
`endif
    endfunction

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %06h, expected %06h", name, act, exp);
        end
    endtask

    task automatic probe(input int sel, input int h, input int v, input logic eh,
                         input logic [23:0] ec, input string name);
        exp_t        e;
        exp_t        got;
        logic        ah;
        logic [23:0] ac;
        @(negedge clk);
        bus1.hcount_in = 11'(h);
        bus1.vcount_in = 10'(v);
        bus3.hcount_in = 11'(h);
        bus3.vcount_in = 10'(v);
        e = '{sel: sel, hit: eh, col: (eh ? ec : 24'h0), name: name};
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        ah = (got.sel == 3) ? bus3.hit_out : bus1.hit_out;
        ac = (got.sel == 3) ? bus3.color_out : bus1.color_out;
        checks++;
        if (ah !== got.hit || ac !== got.col) begin
            errors++;
            $display("FAIL %s: hit=%0b color=%06h, expected hit=%0b color=%06h",
                     got.name, ah, ac, got.hit, got.col);
        end
    endtask

    task automatic pulse(input int sel, input bit nf, input bit clr, input int x, input int y,
                         input bit v);
        @(negedge clk);
        if (sel == 3) begin
            bus3.nf_in = nf; bus3.clear_in = clr;
            bus3.x_in = 11'(x); bus3.y_in = 10'(y); bus3.valid_in = v;
        end else begin
            bus1.nf_in = nf; bus1.clear_in = clr;
            bus1.x_in = 11'(x); bus1.y_in = 10'(y); bus1.valid_in = v;
        end
        @(posedge clk);
        #1;
        bus1.nf_in = 1'b0; bus1.clear_in = 1'b0;
        bus3.nf_in = 1'b0; bus3.clear_in = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[8];

        bus1.nf_in = 0; bus1.clear_in = 0; bus1.hcount_in = 0; bus1.vcount_in = 0;
        bus1.x_in = 0; bus1.y_in = 0; bus1.valid_in = 0; bus1.color_in = COL;
        bus3.nf_in = 0; bus3.clear_in = 0; bus3.hcount_in = 0; bus3.vcount_in = 0;
        bus3.x_in = 0; bus3.y_in = 0; bus3.valid_in = 0; bus3.color_in = COL;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // reset: no phantom sprite at origin
        probe(1, 0, 0, 1'b0, 24'h0, "reset_origin");
        probe(3, 0, 0, 1'b0, 24'h0, "reset_origin_d3");

        // single head sprite, size 16
        pulse(1, 1, 0, 100, 50, 1);
        probe(1, 116, 50, 1'b0, 24'h0, "t2_right_edge_out");
        @(negedge clk);
        bus1.hcount_in = 11'd100;
        bus1.vcount_in = 10'd50;
        #1;
        chk("t2_latency_before_edge", {23'h0, bus1.hit_out}, 24'h0);
        @(posedge clk);
        #1;
        chk("t2_latency_after_edge", {23'h0, bus1.hit_out}, 24'h1);
        probe(1, 100, 50, 1'b1, COL, "t2_head_tl");
        probe(1, 115, 65, 1'b1, COL, "t2_head_br");
        probe(1, 100, 66, 1'b0, 24'h0, "t2_bottom_out");

        // six entries at x=100..200, sizes 16,13,10,7,4,2 by age
        for (int k = 0; k < 6; k++) pulse(1, 1, 0, 100 + 20 * k, 50, 1);
        tbl[0] = '{h: 143, v: 52, hit: 1'b1, age: 3};
        tbl[1] = '{h: 200, v: 50, hit: 1'b1, age: 0};
        tbl[2] = '{h: 192, v: 50, hit: 1'b1, age: 1};
        tbl[3] = '{h: 193, v: 50, hit: 1'b0, age: 0};
        tbl[4] = '{h: 101, v: 51, hit: 1'b1, age: 5};
        tbl[5] = '{h: 102, v: 51, hit: 1'b0, age: 0};
        tbl[6] = '{h: 120, v: 53, hit: 1'b1, age: 4};
        tbl[7] = '{h: 124, v: 50, hit: 1'b0, age: 0};
        for (int i = 0; i < 8; i++)
            probe(1, tbl[i].h, tbl[i].v, tbl[i].hit, exp_col(tbl[i].age),
                  $sformatf("t3_vec%0d", i));

        // overlap of entry0 and entry1: newest wins
        pulse(1, 1, 0, 300, 300, 1);
        pulse(1, 1, 0, 305, 300, 1);
        probe(1, 306, 301, 1'b1, exp_col(0), "t3_overlap_entry0");
        probe(1, 302, 301, 1'b1, exp_col(1), "t3_entry1_only");

        // clear beats a simultaneous accept
        pulse(1, 1, 1, 500, 50, 1);
        probe(1, 306, 301, 1'b0, 24'h0, "t6_cleared_old");
        probe(1, 500, 50, 1'b0, 24'h0, "t6_no_shift");
        probe(1, 143, 52, 1'b0, 24'h0, "t6_cleared_entry");

        // invalid sample leaves a gap
        pulse(1, 1, 0, 400, 100, 1);
        pulse(1, 1, 0, 420, 100, 0);
        pulse(1, 1, 0, 440, 100, 1);
        probe(1, 421, 101, 1'b0, 24'h0, "t6_gap");
        probe(1, 441, 101, 1'b1, exp_col(0), "t6_after_gap");
        probe(1, 401, 101, 1'b1, exp_col(2), "t6_before_gap");

        // right-edge clipping
        pulse(1, 0, 1, 0, 0, 0);
        pulse(1, 1, 0, 2040, 10, 1);
        probe(1, 2040, 10, 1'b1, exp_col(0), "t5_x2040");
        probe(1, 2047, 10, 1'b1, exp_col(0), "t5_x2047");
        probe(1, 0, 10, 1'b0, 24'h0, "t5_nowrap_0");
        probe(1, 7, 10, 1'b0, 24'h0, "t5_nowrap_7");
        probe(1, 2039, 10, 1'b0, 24'h0, "t5_left_out");

        // DECIM=3: accepts on pulses 1,4,7
        for (int k = 1; k <= 9; k++) pulse(3, 1, 0, 30 * k, 200, 1);
        probe(3, 210, 200, 1'b1, exp_col(0), "t4_pulse7");
        probe(3, 120, 200, 1'b1, exp_col(1), "t4_pulse4");
        probe(3, 30, 200, 1'b1, exp_col(2), "t4_pulse1");
        probe(3, 60, 200, 1'b0, 24'h0, "t4_pulse2_skipped");
        probe(3, 90, 200, 1'b0, 24'h0, "t4_pulse3_skipped");
        probe(3, 240, 200, 1'b0, 24'h0, "t4_pulse8_skipped");

        // clear resets the decimation counter
        pulse(3, 1, 0, 600, 400, 1);
        pulse(3, 1, 1, 650, 400, 1);
        pulse(3, 1, 0, 700, 400, 1);
        probe(3, 700, 400, 1'b1, exp_col(0), "t6_cnt_restart");
        probe(3, 600, 400, 1'b0, 24'h0, "t6_d3_cleared");
        probe(3, 650, 400, 1'b0, 24'h0, "t6_d3_no_shift");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
